// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES InvSubBytes over LANES bytes per cycle.
// Optional InvShiftRows merge: define INV_SHIFT_ROWS_EN.

module inv_sbox (
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [7:0] TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign data = TBL[addr];

endmodule

module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int N = 16 / LANES;
    localparam logic [3:0] LAST = 4'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       st;
    logic [3:0]   cnt;
    logic [127:0] src;
    logic [127:0] work;
    logic [127:0] perm;
    logic [127:0] next_work;
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];

    // Input byte that feeds output byte j (row r = j%4, col c = j/4).
    function automatic int src_idx(input int j);
`ifdef INV_SHIFT_ROWS_EN
        int r;
        int c;
        r = j % 4;
        c = j / 4;
        return r + 4 * ((c - r + 4) % 4);
`else
        return j;
`endif
    endfunction

    // Static byte routing; costs only wiring, no cycles.
    for (genvar j = 0; j < 16; j++) begin : g_perm
        assign perm[127-8*j -: 8] = src[127-8*src_idx(j) -: 8];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_sbox (
            .addr (lane_in[l]),
            .data (lane_out[l])
        );
    end

    // Select the current group of source bytes for the S-box lanes.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = perm[127-8*(int'(cnt)*LANES+l) -: 8];
        end
    end

    // Merge this cycle's lane results into the partial result.
    always_comb begin
        next_work = work;
        for (int l = 0; l < LANES; l++) begin
            next_work[127-8*(int'(cnt)*LANES+l) -: 8] = lane_out[l];
        end
    end

    // Control FSM with registered result and out_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            cnt       <= '0;
            src       <= '0;
            work      <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        src <= in_state;
                        cnt <= '0;
                        st  <= RUN;
                    end
                end
                RUN: begin
                    work <= next_work;
                    cnt  <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        out_state <= next_work;
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign in_ready = (st == IDLE) && !reset;
    assign busy     = (st != IDLE);

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequential InvSubBytes stage for the AES decryption datapath. It accepts a 128-bit cipher state and substitutes every byte through `inv_sbox` instances, processing LANES bytes per cycle. It returns the substituted state over a valid/ready handshake. It sits between the AddRoundKey/InvMixColumns output of the previous round and the round-key XOR of the current round, and can optionally absorb InvShiftRows.

## Interface
- LANES, 4, number of `inv_sbox` instances used per cycle; legal values are 1, 2, 4, 8, 16; N = 16/LANES.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a state on in_state.
- in_ready  output  1  block can accept; high only in IDLE and while reset is low.
- in_state  input  128  input state; byte k = in_state[127-8k -: 8], AES column-major, row = k%4, col = k/4.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  substituted state, same byte ordering as in_state.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- Reset values:
  - FSM = IDLE, group counter = 0, work register = 0.
  - out_state = 0, out_valid = 0, busy = 0.
  - in_ready = 0 while reset is high.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch in_state into the source register, clear the counter, and go to RUN.
- RUN:
  - Each cycle, group g = counter drives bytes g·LANES … g·LANES+LANES-1 through the `inv_sbox` instances.
  - Results are written to the same byte positions of the work register; counter increments.
  - After group N-1 is written, load the complete result into out_state and go to DONE. The last group's bytes are forwarded directly, so no extra cycle is needed.
- DONE:
  - out_valid = 1 and out_state is held stable.
  - On out_ready, clear out_valid and go to IDLE.
  - in_ready stays 0 in DONE, so no input is accepted in the same cycle as the output handshake.
- in_state and in_valid are ignored outside IDLE.
- out_state changes only on the RUN→DONE transition and on reset.
- Counter width is 4 bits. The counter never wraps within an operation because the last group is detected at N-1.
- Reset asserted in any state:
  - returns to IDLE with all outputs at reset values on that edge;
  - the partial result is discarded;
  - no out_valid is produced for the aborted state.
- Per-byte substitution is the standard AES inverse S-box, provided by instantiating `inv_sbox` (result = InvS[addr]).

## Timing
- Accept handshake occurs at edge E0. RUN processes groups at edges E1..EN. out_valid is high after edge EN.
- Latency from accept to out_valid is N cycles: 4 cycles at LANES=4, 1 cycle at LANES=16, 16 cycles at LANES=1.
- Minimum initiation interval is N+2 cycles: accept edge, N RUN edges, and at least one DONE edge.
- out_valid stays high for any number of cycles until out_ready is sampled high. out_state is unchanged throughout.
- in_ready and busy are decoded combinationally from the FSM register. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- INV_SHIFT_ROWS_EN defined: the source byte for output byte j = r+4c is input byte r+4·((c−r) mod 4). The block computes InvSubBytes(InvShiftRows(state)), with no extra latency or cycles.
- INV_SHIFT_ROWS_EN undefined: output byte j is taken from input byte j (InvSubBytes only). The shift must then be done by a separate stage.

## Test plan
- **All zeros.** After reset, send in_state = 128'h0 with out_ready = 1.
  - out_state = all bytes 8'h52.
  - out_valid rises exactly N cycles after the accept edge.
- **Identity bytes, no shift.** Macro undefined, in_state bytes 00..0F (byte0 = 00).
  - out_state = 52096ad5_3036a538_bf40a39e_81f3d7fb.
- **Identity bytes, with shift.** INV_SHIFT_ROWS_EN defined, same input.
  - out_state = 52f3a338_3009d79e_bf366afb_8140a5d5.
- **Backpressure.** Send all 0x63 with out_ready held low for 10 cycles.
  - out_state = 128'h0 and stays stable the whole time.
  - out_valid stays 1, in_ready stays 0, and a second in_valid is not accepted.
  - Raise out_ready: out_valid falls on the next edge and in_ready rises.
- **Reset mid-run.** Assert reset at edge E2 of a LANES=4 operation.
  - FSM returns to IDLE with out_state = 0 and out_valid never asserted.
  - A following accept of all 0xFF yields all 0x7D.
- **LANES sweep.** Rerun the second scenario at LANES = 1, 2, 8, 16.
  - Results are identical; latency is 16, 8, 2, 1 cycles respectively.
